// File: rtl/calculator_input_sequencer.sv
// Button/switch front end for the calculator: synchronizes and debounces the
// buttons, steps NUM1 -> NUM2 -> OP -> ANSWER and latches operands.
// Optional: CALC_INPUT_OPCODE_CHECK_EN refuses the all-ones (reserved) opcode.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_NUM1   | entering operand 1; next latches num1
// ST_NUM2   | entering operand 2; next latches num2
// ST_OP     | entering opcode; next latches opcode, pulses valid
// ST_ANSWER | result shown; next returns to NUM1, operands kept
module calculator_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_WIDTH      = 16,
    parameter int OP_WIDTH        = 3
) (
    input  logic                  IN_clk,
    input  logic                  IN_reset,
    input  logic [DATA_WIDTH-1:0] IN_switches,
    input  logic                  IN_prev_button,
    input  logic                  IN_next_button,
    input  logic                  IN_center_button,
    output logic [DATA_WIDTH-1:0] OUT_num1,
    output logic [DATA_WIDTH-1:0] OUT_num2,
    output logic [OP_WIDTH-1:0]   OUT_operation_code,
    output logic                  OUT_operands_valid,
    output logic [1:0]            OUT_stage,
    output logic                  OUT_show_16bit_input,
    output logic                  OUT_show_operation,
    output logic                  OUT_show_answer,
    output logic                  OUT_op_error
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               BTN_PREV   = 0;
    localparam int               BTN_NEXT   = 1;
    localparam int               BTN_CENTER = 2;

    typedef enum logic [1:0] {
        ST_NUM1   = 2'd0,
        ST_NUM2   = 2'd1,
        ST_OP     = 2'd2,
        ST_ANSWER = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sw_s1;
    logic [DATA_WIDTH-1:0] sw_s2;
    logic [2:0]            raw_btn;
    logic [2:0]            btn_s1;
    logic [2:0]            btn_s2;
    logic [2:0]            level;
    logic [2:0]            level_q;
    logic [2:0]            armed;
    logic [2:0]            press;
    logic [CNT_W-1:0]      cnt [3];
    logic                  op_reserved;

    assign raw_btn = {IN_center_button, IN_next_button, IN_prev_button};

    // Button synchronizers reset to "pressed" so a button held through reset
    // cannot masquerade as a fresh press once reset is released.
    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '1;
            btn_s2 <= '1;
        end else begin
            sw_s1  <= IN_switches;
            sw_s2  <= sw_s1;
            btn_s1 <= raw_btn;
            btn_s2 <= btn_s1;
        end
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            level   <= '0;
            level_q <= '0;
            armed   <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            level_q <= level;
            for (int i = 0; i < 3; i++) begin
                if (!btn_s2[i]) armed[i] <= 1'b1;
                if (btn_s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = level & ~level_q & armed;

`ifdef CALC_INPUT_OPCODE_CHECK_EN
    assign op_reserved = &sw_s2[OP_WIDTH-1:0];
`else
    assign op_reserved = 1'b0;
`endif

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            state              <= ST_NUM1;
            OUT_num1           <= '0;
            OUT_num2           <= '0;
            OUT_operation_code <= '0;
            OUT_operands_valid <= 1'b0;
            OUT_op_error       <= 1'b0;
        end else begin
            OUT_operands_valid <= 1'b0;
            OUT_op_error       <= 1'b0;
            if (press[BTN_CENTER]) begin
                state              <= ST_NUM1;
                OUT_num1           <= '0;
                OUT_num2           <= '0;
                OUT_operation_code <= '0;
            end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
                case (state)
                    ST_NUM2:   state <= ST_NUM1;
                    ST_OP:     state <= ST_NUM2;
                    ST_ANSWER: state <= ST_OP;
                    default:   state <= ST_NUM1;
                endcase
            end else if (press[BTN_NEXT] && !press[BTN_PREV]) begin
                case (state)
                    ST_NUM1: begin
                        OUT_num1 <= sw_s2;
                        state    <= ST_NUM2;
                    end
                    ST_NUM2: begin
                        OUT_num2 <= sw_s2;
                        state    <= ST_OP;
                    end
                    ST_OP: begin
                        if (op_reserved) begin
                            OUT_op_error <= 1'b1;
                        end else begin
                            OUT_operation_code <= sw_s2[OP_WIDTH-1:0];
                            OUT_operands_valid <= 1'b1;
                            state              <= ST_ANSWER;
                        end
                    end
                    default: state <= ST_NUM1;
                endcase
            end
        end
    end

    assign OUT_stage            = state;
    assign OUT_show_16bit_input = (state == ST_NUM1) || (state == ST_NUM2);
    assign OUT_show_operation   = (state == ST_OP);
    assign OUT_show_answer      = (state == ST_ANSWER);

endmodule

// File: tb/tb_calculator_input_sequencer.sv
// Self-checking bench for calculator_input_sequencer: directed scenarios plus
// randomized button/switch sequences against a stage-level reference model.
module tb_calculator_input_sequencer;

    localparam int D = 4;
`ifdef CALC_INPUT_OPCODE_CHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        pb, nb, cb;
    logic [15:0] num1, num2;
    logic [2:0]  opc;
    logic        valid, err, show16, showop, showans;
    logic [1:0]  stage;

    always #5 clk = ~clk;

    calculator_input_sequencer #(.DEBOUNCE_CYCLES(D), .DATA_WIDTH(16), .OP_WIDTH(3)) dut (
        .IN_clk(clk),
        .IN_reset(rst),
        .IN_switches(sw),
        .IN_prev_button(pb),
        .IN_next_button(nb),
        .IN_center_button(cb),
        .OUT_num1(num1),
        .OUT_num2(num2),
        .OUT_operation_code(opc),
        .OUT_operands_valid(valid),
        .OUT_stage(stage),
        .OUT_show_16bit_input(show16),
        .OUT_show_operation(showop),
        .OUT_show_answer(showans),
        .OUT_op_error(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int   valid_cnt = 0;
    int   err_cnt = 0;
    int   dbl_valid = 0;
    logic valid_d = 1'b0;
    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
        if (err === 1'b1) err_cnt++;
        if (valid === 1'b1 && valid_d === 1'b1) dbl_valid++;
        valid_d = valid;
    end

    // Reference model: what the operator-visible state should be after each press
    int          m_stage;
    logic [15:0] m_num1, m_num2;
    logic [2:0]  m_op;
    int          exp_valid = 0;
    int          exp_err = 0;

    task automatic model_reset();
        m_stage = 0; m_num1 = 0; m_num2 = 0; m_op = 0;
    endtask

    task automatic model_step(input bit p, input bit n, input bit c, input logic [15:0] s);
        if (c) begin
            model_reset();
        end else if (p && n) begin
            // simultaneous prev and next cancel each other
        end else if (p) begin
            m_stage = (m_stage == 0) ? 0 : m_stage - 1;
        end else if (n) begin
            if (m_stage == 0) begin
                m_num1 = s; m_stage = 1;
            end else if (m_stage == 1) begin
                m_num2 = s; m_stage = 2;
            end else if (m_stage == 2) begin
                if (OPCHK && s[2:0] == 3'b111) begin
                    exp_err++;
                end else begin
                    m_op = s[2:0]; m_stage = 3; exp_valid++;
                end
            end else begin
                m_stage = 0;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_stage"}, 32'(stage), 32'(m_stage));
        chk({tag, "_num1"}, 32'(num1), 32'(m_num1));
        chk({tag, "_num2"}, 32'(num2), 32'(m_num2));
        chk({tag, "_op"}, 32'(opc), 32'(m_op));
        chk({tag, "_show16"}, 32'(show16), 32'(m_stage < 2));
        chk({tag, "_showop"}, 32'(showop), 32'(m_stage == 2));
        chk({tag, "_showans"}, 32'(showans), 32'(m_stage == 3));
    endtask

    task automatic press(input bit p, input bit n, input bit c, input logic [15:0] s, input int hold);
        sw = s; pb = p; nb = n; cb = c;
        repeat (hold) @(negedge clk);
        pb = 1'b0; nb = 1'b0; cb = 1'b0;
        sw = 16'($urandom);
        repeat (12) @(negedge clk);
        model_step(p, n, c, s);
    endtask

    logic [8:0]  vbits;
    int          kind;
    logic [15:0] rsw;

    initial begin
        rst = 1'b1; sw = 16'h0; pb = 1'b0; nb = 1'b0; cb = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_state("reset");
        chk("reset_valid_cnt", 32'(valid_cnt), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // three commits; latency of the third measured from the raw edge
        press(1'b0, 1'b1, 1'b0, 16'h1234, 10);
        press(1'b0, 1'b1, 1'b0, 16'h00FF, 10);
        sw = 16'h0002; nb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            vbits[i] = valid;
        end
        chk("valid_latency", 32'(vbits), 32'h040);
        nb = 1'b0;
        repeat (12) @(negedge clk);
        model_step(1'b0, 1'b1, 1'b0, 16'h0002);
        check_state("seq3");
        chk("seq3_num1_lit", 32'(num1), 32'h1234);
        chk("seq3_valid_cnt", 32'(valid_cnt), 32'(exp_valid));

        // held button: one action only; short glitches: none
        press(1'b0, 1'b0, 1'b1, 16'hAAAA, 10);
        press(1'b0, 1'b1, 1'b0, 16'h5A5A, 50);
        check_state("held");
        for (int g = 0; g < 5; g++) begin
            nb = 1'b1; repeat (2) @(negedge clk);
            nb = 1'b0; repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_state("glitch");

        press(1'b0, 1'b1, 1'b0, 16'hBEEF, 10);
        press(1'b1, 1'b0, 1'b0, 16'h1111, 10);
        check_state("prev_op");
        press(1'b1, 1'b1, 1'b0, 16'h2222, 10);
        check_state("prev_next");
        press(1'b0, 1'b1, 1'b0, 16'hCAFE, 10);
        press(1'b0, 1'b1, 1'b0, 16'h0005, 10);
        check_state("answer");
        press(1'b0, 1'b0, 1'b1, 16'h3333, 10);
        check_state("center");
        chk("center_num2_zero", 32'(num2), 32'd0);

        // reset while next is mid-debounce in NUM2
        press(1'b0, 1'b1, 1'b0, 16'h7777, 10);
        sw = 16'h4444; nb = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_state("rst_mid");
        chk("rst_mid_valid", 32'(valid), 32'd0);
        repeat (20) @(negedge clk);
        check_state("rst_held");
        nb = 1'b0;
        repeat (12) @(negedge clk);
        check_state("rst_release");
        press(1'b0, 1'b1, 1'b0, 16'h9999, 10);
        check_state("rst_after");

        // reserved opcode
        press(1'b0, 1'b1, 1'b0, 16'h0101, 10);
        press(1'b0, 1'b1, 1'b0, 16'hFFFF, 10);
        check_state("op_rsvd");
        chk("op_rsvd_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("op_rsvd_valid_cnt", 32'(valid_cnt), 32'(exp_valid));

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            rsw  = 16'($urandom);
            case (kind)
                0:       press(1'b0, 1'b0, 1'b1, rsw, int'($urandom_range(8, 14)));
                1, 2:    press(1'b1, 1'b0, 1'b0, rsw, int'($urandom_range(8, 14)));
                3:       press(1'b1, 1'b1, 1'b0, rsw, int'($urandom_range(8, 14)));
                default: press(1'b0, 1'b1, 1'b0, rsw, int'($urandom_range(8, 14)));
            endcase
            check_state($sformatf("rand%0d", it));
        end

        chk("final_valid_cnt", 32'(valid_cnt), 32'(exp_valid));
        chk("final_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("final_valid_width", 32'(dbl_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calculator_input_sequencer.md
Name: calculator_input_sequencer

Overview:
- Input-side counterpart of the calculator display path: turns raw board buttons and switches into latched operands for the arithmetic unit, and drives the stage flags the seven-segment display consumes.
- Debounces and edge-detects the prev/next/center buttons and steps a four-stage entry FSM: NUM1 → NUM2 → OP → ANSWER.
- Captures the switch bank at each stage commit and issues a one-cycle operands-valid strobe to the ALU.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a button level (10 ms at 100 MHz clk).
- DATA_WIDTH, 16, width of switch bank and each operand.
- OP_WIDTH, 3, width of operation code, taken from IN_switches[OP_WIDTH-1:0].

Ports:
- IN_clk  input  1  system clock; all logic on rising edge.
- IN_reset  input  1  synchronous, active-high reset.
- IN_switches  input  DATA_WIDTH  raw slide switches, asynchronous to clk.
- IN_prev_button  input  1  raw button, asynchronous; step back one stage.
- IN_next_button  input  1  raw button, asynchronous; commit and advance.
- IN_center_button  input  1  raw button, asynchronous; soft clear.
- OUT_num1  output  DATA_WIDTH  latched operand 1.
- OUT_num2  output  DATA_WIDTH  latched operand 2.
- OUT_operation_code  output  OP_WIDTH  latched opcode.
- OUT_operands_valid  output  1  one-cycle strobe; num1/num2/opcode are coherent.
- OUT_stage  output  2  0=NUM1, 1=NUM2, 2=OP, 3=ANSWER.
- OUT_show_16bit_input  output  1  high in NUM1 or NUM2.
- OUT_show_operation  output  1  high in OP.
- OUT_show_answer  output  1  high in ANSWER.
- OUT_op_error  output  1  one-cycle strobe on rejected opcode (see Optional Feature).

Behaviour:
- Single clock, IN_clk. Reset is synchronous, active-high on IN_reset; it is sampled only on the rising edge.
- Reset values: stage=NUM1; num1=0, num2=0, opcode=0; valid=0, op_error=0. show_16bit_input=1, other show flags 0. Debounce counters=0; debounced levels=0.
- Synchronizers: each button passes through a 2-FF synchronizer; IN_switches passes through a 2-FF synchronizer bank. Latches always use the synchronized switches.
- Debounce, per button:
  - Counter increments while the synchronized sample differs from the debounced level.
  - Counter clears to 0 when the sample equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a 1-cycle press pulse.
- Press priority in one cycle: center > prev > next. If prev and next pulse together without center, neither acts.
- FSM, acting in the press-pulse cycle; state and registers update at that cycle's closing edge:
  - NUM1 + next: num1 ← switches; go to NUM2.
  - NUM2 + next: num2 ← switches; go to OP.
  - OP + next: opcode ← switches[OP_WIDTH-1:0]; go to ANSWER; OUT_operands_valid high for exactly the following cycle.
  - ANSWER + next: go to NUM1. Operands are retained and valid is not pulsed.
  - prev: step back one stage with no latch. prev in NUM1 stays in NUM1.
  - center, any stage: num1, num2, opcode ← 0; go to NUM1; no valid pulse.
- Latency: a raw button edge held stable produces its FSM action 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later.
- Show flags and OUT_stage are decoded from the registered state, so they are glitch-free.
- Held button: exactly one action per press. Release produces no action.
- Reset mid-debounce or mid-stage aborts everything to reset values. Any press in progress must be fully released and re-debounced before it acts.
- Switch changes outside a next-commit cycle have no effect on the outputs.

Optional Feature:
- Macro: CALC_INPUT_OPCODE_CHECK_EN.
- Defined: in OP, next with switches[OP_WIDTH-1:0] == all-ones (reserved opcode) is refused. Stage stays OP, opcode is unchanged, no valid pulse, and OUT_op_error is high for the following cycle.
- Undefined: all opcodes are accepted and OUT_op_error is tied 0.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle 20 cycles → stage=0, num1=num2=opcode=0, valid never high, show_16bit_input=1.
- sw=16'h1234 + next press; sw=16'h00FF + next; sw=3'b010 + next → num1=1234, num2=00FF, opcode=2. Valid is high exactly 1 cycle, 2+4+1 cycles after the third press; stage=3, show_answer=1.
- next held high for 50 cycles in NUM1 → single advance to NUM2. Next toggled for 2-cycle glitches → no advance.
- In OP, prev press → stage=1, num2 unchanged. Prev+next pulsed same cycle → no change. Center in ANSWER → all operands 0, stage=0.
- IN_reset asserted during a 3rd-cycle debounce count in NUM2 → reset values next edge, and that press does not act after reset.
- With CALC_INPUT_OPCODE_CHECK_EN defined: OP with sw[2:0]=3'b111 + next → stage stays 2, op_error 1 cycle, valid 0. Without the macro: stage=3 and valid pulses.
